// File: rtl/inst_rom_axil_slave_pkg.sv
// Shared definitions for the instruction-ROM AXI4-Lite responder:
// response codes, bus widths and the byte-lane merge used by the write port.
package inst_rom_axil_slave_pkg;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   localparam int AXI_ADDR_BUS = 32;
   localparam int AXI_DATA_BUS = 32;
   localparam int AXI_STRB_BUS = AXI_DATA_BUS / 8;

   // Replace the byte lanes of old_word selected by strb with lanes of new_word.
   function automatic logic [AXI_DATA_BUS-1:0] byte_merge(
      input logic [AXI_DATA_BUS-1:0] old_word,
      input logic [AXI_DATA_BUS-1:0] new_word,
      input logic [AXI_STRB_BUS-1:0] strb
   );
      logic [AXI_DATA_BUS-1:0] result;
      result = old_word;
      for (int i = 0; i < AXI_STRB_BUS; i++) begin
         if (strb[i]) result[i*8 +: 8] = new_word[i*8 +: 8];
      end
      return result;
   endfunction

endpackage

// File: rtl/inst_rom_axil_slave_mem.sv
// Word array behind the instruction ROM port. Contents are supplied by the
// environment. Registered read port; a byte-enable write port exists
// only when INST_ROM_WRITE_EN is defined. Read and write share one process so
// a same-word read at the write edge returns the pre-write value.
module inst_rom_mem
   import inst_rom_axil_slave_pkg::*;
#(
   parameter int    DATA_WIDTH = 32,
   parameter int    DEPTH_LOG2 = 10,
   parameter string INIT_FILE  = "inst_rom.data"
) (
   input  logic                    clk,
`ifdef INST_ROM_WRITE_EN
   input  logic                    i_wr_en,
   input  logic [DEPTH_LOG2-1:0]   i_wr_idx,
   input  logic [DATA_WIDTH-1:0]   i_wr_data,
   input  logic [DATA_WIDTH/8-1:0] i_wr_strb,
`endif
   input  logic                    i_rd_en,
   input  logic [DEPTH_LOG2-1:0]   i_rd_idx,
   output logic [DATA_WIDTH-1:0]   o_rd_data
);

   logic [DATA_WIDTH-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];
   logic [DATA_WIDTH-1:0] r_rd_data;

   // Synchronous read (read-first) and optional byte-lane write.
   always_ff @(posedge clk) begin
      if (i_rd_en) r_rd_data <= r_mem[i_rd_idx];
`ifdef INST_ROM_WRITE_EN
      if (i_wr_en) r_mem[i_wr_idx] <= byte_merge(r_mem[i_wr_idx], i_wr_data, i_wr_strb);
`endif
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/inst_rom_axil_slave.sv
// AXI4-Lite responder for the instruction ROM: one outstanding read with
// one-cycle latency, write channels always handshaken. Define
// INST_ROM_WRITE_EN to make writes update the array; otherwise every write
// is answered SLVERR and the array stays read-only.
module inst_rom_axil_slave
   import inst_rom_axil_slave_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    DEPTH_LOG2 = 10,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter string                 INIT_FILE  = "inst_rom.data"
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ADDR_WIDTH-1:0]   araddr,
   input  logic                    arvalid,
   output logic                    arready,
   output logic [DATA_WIDTH-1:0]   rdata,
   output logic [1:0]              rresp,
   output logic                    rvalid,
   input  logic                    rready,
   input  logic [ADDR_WIDTH-1:0]   awaddr,
   input  logic                    awvalid,
   output logic                    awready,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
   input  logic                    wvalid,
   output logic                    wready,
   output logic [1:0]              bresp,
   output logic                    bvalid,
   input  logic                    bready
);

   localparam int OFS_HI = DEPTH_LOG2 + 2;

   typedef enum logic {R_IDLE = 1'b0, R_RESP = 1'b1} rd_state_t;

   rd_state_t r_rd_state, w_rd_state_next;
   logic      r_arready, r_rvalid, r_rd_err;
   logic [1:0] r_rresp;
   logic      r_aw_held, r_w_held, r_awready, r_wready, r_bvalid;
   logic [1:0] r_bresp;
   logic      w_aw_held_next, w_w_held_next, w_bvalid_next;

   // Read address decode: word index and in-range test relative to BASE_ADDR.
   logic [ADDR_WIDTH-1:0] w_rd_offset;
   logic                  w_rd_ok, w_ar_fire;
   logic [DATA_WIDTH-1:0] w_mem_rdata;
   logic                  w_unused_bits;
   assign w_rd_offset = araddr - BASE_ADDR;
   assign w_rd_ok     = (araddr >= BASE_ADDR) && (w_rd_offset[ADDR_WIDTH-1:OFS_HI] == '0);
   assign w_ar_fire   = arvalid && r_arready;

   // Write-side handshakes; a write commits on the first edge with both halves held.
   logic w_aw_fire, w_w_fire, w_b_fire, w_aw_have, w_w_have, w_commit;
   assign w_aw_fire = awvalid && r_awready;
   assign w_w_fire  = wvalid && r_wready;
   assign w_b_fire  = r_bvalid && bready;
   assign w_aw_have = r_aw_held || w_aw_fire;
   assign w_w_have  = r_w_held || w_w_fire;
   assign w_commit  = !r_bvalid && w_aw_have && w_w_have;

`ifdef INST_ROM_WRITE_EN
   logic [ADDR_WIDTH-1:0]   r_awaddr, w_wr_addr, w_wr_offset;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic [DATA_WIDTH/8-1:0] r_wstrb;
   logic                    w_wr_ok;
   assign w_wr_addr     = r_aw_held ? r_awaddr : awaddr;
   assign w_wr_offset   = w_wr_addr - BASE_ADDR;
   assign w_wr_ok       = (w_wr_addr >= BASE_ADDR) && (w_wr_offset[ADDR_WIDTH-1:OFS_HI] == '0);
   assign w_unused_bits = ^{w_rd_offset[1:0], w_wr_offset[1:0]};

   // Hold write address/data until the commit edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_awaddr <= '0;
         r_wdata  <= '0;
         r_wstrb  <= '0;
      end else begin
         if (w_aw_fire) r_awaddr <= awaddr;
         if (w_w_fire) begin
            r_wdata <= wdata;
            r_wstrb <= wstrb;
         end
      end
   end
`else
   assign w_unused_bits = ^{w_rd_offset[1:0], awaddr, wdata, wstrb};
`endif

   inst_rom_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH_LOG2 (DEPTH_LOG2),
      .INIT_FILE  (INIT_FILE)
   ) u_mem (
      .clk       (clk),
`ifdef INST_ROM_WRITE_EN
      .i_wr_en   (w_commit && w_wr_ok),
      .i_wr_idx  (w_wr_offset[OFS_HI-1:2]),
      .i_wr_data (r_w_held ? r_wdata : wdata),
      .i_wr_strb (r_w_held ? r_wstrb : wstrb),
`endif
      .i_rd_en   (w_ar_fire),
      .i_rd_idx  (w_rd_offset[OFS_HI-1:2]),
      .o_rd_data (w_mem_rdata)
   );

   // Next-state logic for the read FSM and the write capture flags.
   always_comb begin
      w_rd_state_next = r_rd_state;
      w_aw_held_next  = w_b_fire ? 1'b0 : w_aw_have;
      w_w_held_next   = w_b_fire ? 1'b0 : w_w_have;
      w_bvalid_next   = r_bvalid;
      case (r_rd_state)
         R_IDLE:  if (w_ar_fire) w_rd_state_next = R_RESP;
         R_RESP:  if (rready)    w_rd_state_next = R_IDLE;
         default: w_rd_state_next = R_IDLE;
      endcase
      if (w_commit)      w_bvalid_next = 1'b1;
      else if (w_b_fire) w_bvalid_next = 1'b0;
   end

   // Read channel registers; ready and valid follow the next state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_state <= R_IDLE;
         r_arready  <= 1'b0;
         r_rvalid   <= 1'b0;
         r_rd_err   <= 1'b0;
         r_rresp    <= AXI_RESP_OKAY;
      end else begin
         r_rd_state <= w_rd_state_next;
         r_arready  <= (w_rd_state_next == R_IDLE);
         r_rvalid   <= (w_rd_state_next == R_RESP);
         if (w_ar_fire) begin
            r_rd_err <= !w_rd_ok;
            r_rresp  <= w_rd_ok ? AXI_RESP_OKAY : AXI_RESP_DECERR;
         end
      end
   end

   // Write channel flags, readies and response.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= AXI_RESP_OKAY;
      end else begin
         r_aw_held <= w_aw_held_next;
         r_w_held  <= w_w_held_next;
         r_awready <= !w_aw_held_next && !w_bvalid_next;
         r_wready  <= !w_w_held_next && !w_bvalid_next;
         r_bvalid  <= w_bvalid_next;
         if (w_commit) begin
`ifdef INST_ROM_WRITE_EN
            r_bresp <= w_wr_ok ? AXI_RESP_OKAY : AXI_RESP_DECERR;
`else
            r_bresp <= AXI_RESP_SLVERR;
`endif
         end
      end
   end

   assign arready = r_arready;
   assign rvalid  = r_rvalid;
   assign rresp   = r_rresp;
   assign rdata   = (r_rvalid && !r_rd_err) ? w_mem_rdata : '0;
   assign awready = r_awready;
   assign wready  = r_wready;
   assign bvalid  = r_bvalid;
   assign bresp   = r_bresp;

endmodule

// File: tb/tb_inst_rom_axil_slave.sv
// Directed bench for inst_rom_axil_slave. The array is preloaded by the bench
// (INIT_FILE is empty). Expected write behaviour follows INST_ROM_WRITE_EN.
module tb_inst_rom_axil_slave;

   localparam logic [31:0] W0 = 32'h3401_1100;
   localparam logic [31:0] W1 = 32'hA1B2_C3D4;
   localparam logic [31:0] W2 = 32'h0BAD_F00D;
   localparam logic [31:0] W3 = 32'hCAFE_0001;
   localparam logic [31:0] W4 = 32'h5555_AAAA;
`ifdef INST_ROM_WRITE_EN
   localparam logic [31:0] EXP_BRESP_OK  = 32'd0;
   localparam logic [31:0] EXP_W2_AFTER  = 32'hDEAD_BEEF;
   localparam logic [31:0] EXP_W3_AFTER  = 32'hCAFE_5678;
`else
   localparam logic [31:0] EXP_BRESP_OK  = 32'd2;
   localparam logic [31:0] EXP_W2_AFTER  = W2;
   localparam logic [31:0] EXP_W3_AFTER  = W3;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] araddr, rdata, awaddr, wdata;
   logic        arvalid, arready, rvalid, rready;
   logic [1:0]  rresp, bresp;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic [3:0]  wstrb;
   int          n_checks = 0;
   int          n_pass   = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;

   inst_rom_axil_slave #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .DEPTH_LOG2 (10),
      .BASE_ADDR  (32'h0000_0000),
      .INIT_FILE  ("")
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .araddr  (araddr),
      .arvalid (arvalid),
      .arready (arready),
      .rdata   (rdata),
      .rresp   (rresp),
      .rvalid  (rvalid),
      .rready  (rready),
      .awaddr  (awaddr),
      .awvalid (awvalid),
      .awready (awready),
      .wdata   (wdata),
      .wstrb   (wstrb),
      .wvalid  (wvalid),
      .wready  (wready),
      .bresp   (bresp),
      .bvalid  (bvalid),
      .bready  (bready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present an AR beat, wait (bounded) for acceptance; returns one negedge after the accepting edge.
   task automatic ar_send(input logic [31:0] addr);
      int i;
      araddr  = addr;
      arvalid = 1'b1;
      i = 0;
      while (!arready && i < 20) begin
         @(negedge clk);
         i++;
      end
      chk("ar_ready_seen", {31'b0, arready}, 32'd1);
      @(negedge clk);
      arvalid = 1'b0;
      $display("read  addr=%h rvalid=%0d rdata=%h rresp=%0d", addr, rvalid, rdata, rresp);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
      awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
      dut.u_mem.r_mem[0] = W0;
      dut.u_mem.r_mem[1] = W1;
      dut.u_mem.r_mem[2] = W2;
      dut.u_mem.r_mem[3] = W3;
      dut.u_mem.r_mem[4] = W4;
      repeat (2) @(negedge clk);

      // Reset state
      chk("rst_arready", {31'b0, arready}, 32'd0);
      chk("rst_rvalid",  {31'b0, rvalid},  32'd0);
      chk("rst_rdata",   rdata,            32'd0);
      chk("rst_rresp",   {30'b0, rresp},   32'd0);
      chk("rst_awready", {31'b0, awready}, 32'd0);
      chk("rst_wready",  {31'b0, wready},  32'd0);
      chk("rst_bvalid",  {31'b0, bvalid},  32'd0);
      chk("rst_bresp",   {30'b0, bresp},   32'd0);
      rst = 1'b1;
      #1;
      chk("rel_no_edge_arready", {31'b0, arready}, 32'd0);
      @(negedge clk);
      chk("rel_arready", {31'b0, arready}, 32'd1);
      chk("rel_awready", {31'b0, awready}, 32'd1);
      chk("rel_wready",  {31'b0, wready},  32'd1);

      // Single read of word 0
      rready = 1'b1;
      ar_send(32'h0);
      chk("rd0_rvalid",  {31'b0, rvalid},  32'd1);
      chk("rd0_rdata",   rdata,            W0);
      chk("rd0_rresp",   {30'b0, rresp},   32'd0);
      chk("rd0_arready", {31'b0, arready}, 32'd0);
      @(negedge clk);
      chk("rd0_done_rvalid",  {31'b0, rvalid},  32'd0);
      chk("rd0_done_arready", {31'b0, arready}, 32'd1);

      // Backpressure on R
      rready = 1'b0;
      ar_send(32'h4);
      chk("bp_rdata_first", rdata, W1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_rvalid",  {31'b0, rvalid},  32'd1);
         chk("bp_rdata",   rdata,            W1);
         chk("bp_arready", {31'b0, arready}, 32'd0);
      end
      rready = 1'b1;
      @(negedge clk);
      chk("bp_done_rvalid",  {31'b0, rvalid},  32'd0);
      chk("bp_done_arready", {31'b0, arready}, 32'd1);

      // Out of range, then in-range, then unaligned address
      ar_send(32'h0000_1000);
      chk("oor_rdata", rdata,          32'd0);
      chk("oor_rresp", {30'b0, rresp}, 32'd3);
      @(negedge clk);
      ar_send(32'h8);
      chk("w2_rdata", rdata,          W2);
      chk("w2_rresp", {30'b0, rresp}, 32'd0);
      @(negedge clk);
      ar_send(32'h7);
      chk("unal_rdata", rdata, W1);
      @(negedge clk);

      // Write: AW first, W two cycles later, B held then released
      awaddr = 32'h8; awvalid = 1'b1;
      @(negedge clk);
      awvalid = 1'b0;
      chk("aw_only_awready", {31'b0, awready}, 32'd0);
      chk("aw_only_wready",  {31'b0, wready},  32'd1);
      chk("aw_only_bvalid",  {31'b0, bvalid},  32'd0);
      @(negedge clk);
      chk("aw_wait_bvalid", {31'b0, bvalid}, 32'd0);
      wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1;
      @(negedge clk);
      wvalid = 1'b0;
      $display("write addr=%h wdata=%h bvalid=%0d bresp=%0d", 32'h8, 32'hDEAD_BEEF, bvalid, bresp);
      chk("wr1_bvalid",  {31'b0, bvalid},  32'd1);
      chk("wr1_bresp",   {30'b0, bresp},   EXP_BRESP_OK);
      chk("wr1_wready",  {31'b0, wready},  32'd0);
      chk("wr1_awready", {31'b0, awready}, 32'd0);
      @(negedge clk);
      chk("wr1_hold_bvalid", {31'b0, bvalid}, 32'd1);
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
      chk("wr1_done_bvalid",  {31'b0, bvalid},  32'd0);
      chk("wr1_done_awready", {31'b0, awready}, 32'd1);
      chk("wr1_done_wready",  {31'b0, wready},  32'd1);
      ar_send(32'h8);
      chk("wr1_reread", rdata, EXP_W2_AFTER);
      @(negedge clk);

      // Write: AW and W in the same cycle, partial strobe
      awaddr = 32'hC; awvalid = 1'b1;
      wdata = 32'h1234_5678; wstrb = 4'b0011; wvalid = 1'b1; bready = 1'b1;
      @(negedge clk);
      awvalid = 1'b0; wvalid = 1'b0;
      $display("write addr=%h wdata=%h bvalid=%0d bresp=%0d", 32'hC, 32'h1234_5678, bvalid, bresp);
      chk("wr2_bvalid", {31'b0, bvalid}, 32'd1);
      chk("wr2_bresp",  {30'b0, bresp},  EXP_BRESP_OK);
      @(negedge clk);
      bready = 1'b0;
      chk("wr2_done_bvalid", {31'b0, bvalid}, 32'd0);
      ar_send(32'hC);
      chk("wr2_reread", rdata, EXP_W3_AFTER);
      @(negedge clk);

      // Async reset with both R and B beats pending
      araddr = 32'h0; arvalid = 1'b1; rready = 1'b0;
      awaddr = 32'h10; awvalid = 1'b1; wdata = 32'hFFFF_FFFF; wstrb = 4'h0; wvalid = 1'b1; bready = 1'b0;
      @(negedge clk);
      arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
      chk("pend_rvalid", {31'b0, rvalid}, 32'd1);
      chk("pend_bvalid", {31'b0, bvalid}, 32'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_rvalid",  {31'b0, rvalid},  32'd0);
      chk("arst_bvalid",  {31'b0, bvalid},  32'd0);
      chk("arst_rdata",   rdata,            32'd0);
      chk("arst_arready", {31'b0, arready}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("arst_rel_arready", {31'b0, arready}, 32'd1);
      chk("arst_rel_awready", {31'b0, awready}, 32'd1);
      chk("arst_rel_wready",  {31'b0, wready},  32'd1);
      rready = 1'b1;
      ar_send(32'h0);
      chk("arst_word0", rdata, W0);
      @(negedge clk);
      ar_send(32'h10);
      chk("arst_word4", rdata, W4);
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
